// File: rtl/avg_pkg.sv
// Shared defaults, sum-width helper, per-channel state type and window clamp
// for multich_averager.
package avg_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int MAX_LOG_DEF = 8;
  localparam int NUM_CH_DEF  = 2;

  // The sum holds up to 2**max_log samples of data_w bits, so it never overflows.
  function automatic int sum_width(input int data_w, input int max_log);
    return data_w + max_log;
  endfunction

  // Per-channel state at the default geometry.
  typedef struct packed {
    logic [MAX_LOG_DEF-1:0]            ptr;
    logic [MAX_LOG_DEF:0]              fill;
    logic [DATA_W_DEF+MAX_LOG_DEF-1:0] sum;
  } ch_state_t;

  // Maps an out-of-range window request onto the nearest legal value.
  function automatic int clamp_win(input int wl, input int max_log);
    if (wl < 1) begin
      return 1;
    end
    if (wl > max_log) begin
      return max_log;
    end
    return wl;
  endfunction

endpackage

// File: rtl/avg_sample_ram.sv
// Simple dual-port 1R1W sample buffer with registered read and no reset.
module avg_sample_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; holds its data while re_i is low.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/multich_averager.sv
// Multi-channel boxcar averager over a runtime power-of-two window.
// Optional: define AVERAGER_ROUND_EN for round-half-up output with saturation.
module multich_averager
  import avg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_LOG = MAX_LOG_DEF,
  parameter int NUM_CH  = NUM_CH_DEF,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WL_W   = $clog2(MAX_LOG + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [WL_W-1:0]   win_log,
  input  logic              din_valid,
  input  logic [CH_W-1:0]   din_ch,
  input  logic [DATA_W-1:0] din,
  output logic              dout_valid,
  output logic [CH_W-1:0]   dout_ch,
  output logic [DATA_W-1:0] dout
);

  localparam int SUM_W = sum_width(DATA_W, MAX_LOG);
  localparam int AW    = CH_W + MAX_LOG;

  typedef struct packed {
    logic [MAX_LOG-1:0] ptr;
    logic [MAX_LOG:0]   fill;
    logic [SUM_W-1:0]   sum;
  } chan_state_t;

  chan_state_t st_q [NUM_CH];
  chan_state_t st_d [NUM_CH];

  logic [WL_W-1:0]    win_q, win_cl;
  logic               win_chg, ch_ok, accept;
  logic [CH_W-1:0]    ch_idx;
  logic [MAX_LOG:0]   win_sz;
  logic [MAX_LOG-1:0] ptr_last;

  logic               s1_v_q, s2_v_q, s3_v_q;
  logic [DATA_W-1:0]  s1_din_q, s2_din_q;
  logic [CH_W-1:0]    s1_ch_q, s2_ch_q, s3_ch_q;
  logic [MAX_LOG-1:0] s1_ptr_q, s2_ptr_q;
  logic               s1_full_q, s2_full_q;
  logic [SUM_W-1:0]   s3_sum_q, sum_new;
  logic [DATA_W-1:0]  ram_q, scaled;

  logic               dout_valid_q;
  logic [CH_W-1:0]    dout_ch_q;
  logic [DATA_W-1:0]  dout_q;

  // Acceptance, window-change detection and active window geometry.
  always_comb begin
    win_cl   = WL_W'(clamp_win(int'(win_log), MAX_LOG));
    win_chg  = en && (win_cl != win_q);
    ch_ok    = int'(din_ch) < NUM_CH;
    accept   = en && din_valid && ch_ok && !win_chg;
    ch_idx   = ch_ok ? din_ch : '0;
    win_sz   = (MAX_LOG+1)'(1) << win_q;
    ptr_last = MAX_LOG'(win_sz - (MAX_LOG+1)'(1));
    sum_new  = st_q[s2_ch_q].sum + SUM_W'(s2_din_q) - (s2_full_q ? SUM_W'(ram_q) : '0);
  end

  // Per-channel next state: sum update from S2, ptr/fill advance on acceptance.
  always_comb begin
    st_d = st_q;
    if (win_chg) begin
      st_d = '{default: '0};
    end else begin
      if (s2_v_q) begin
        st_d[s2_ch_q].sum = sum_new;
      end
      if (accept) begin
        st_d[ch_idx].ptr = (st_q[ch_idx].ptr == ptr_last) ? '0 : st_q[ch_idx].ptr + MAX_LOG'(1);
        if (st_q[ch_idx].fill != win_sz) begin
          st_d[ch_idx].fill = st_q[ch_idx].fill + (MAX_LOG+1)'(1);
        end
      end
    end
  end

  // Per-channel state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= '{default: '0};
    end else if (en) begin
      st_q <= st_d;
    end
  end

  // Latched window and pipeline valid bits; a window change flushes in-flight samples.
  // The extra stage between S1 and the sum update carries the registered RAM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q  <= '0;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s3_v_q <= 1'b0;
    end else if (en) begin
      win_q  <= win_cl;
      s1_v_q <= accept;
      s2_v_q <= s1_v_q & ~win_chg;
      s3_v_q <= s2_v_q & ~win_chg;
    end
  end

  // Pipeline data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_din_q  <= '0;
      s1_ch_q   <= '0;
      s1_ptr_q  <= '0;
      s1_full_q <= 1'b0;
      s2_din_q  <= '0;
      s2_ch_q   <= '0;
      s2_ptr_q  <= '0;
      s2_full_q <= 1'b0;
      s3_ch_q   <= '0;
      s3_sum_q  <= '0;
    end else if (en) begin
      if (accept) begin
        s1_din_q  <= din;
        s1_ch_q   <= din_ch;
        s1_ptr_q  <= st_q[ch_idx].ptr;
        s1_full_q <= (st_q[ch_idx].fill == win_sz);
      end
      s2_din_q  <= s1_din_q;
      s2_ch_q   <= s1_ch_q;
      s2_ptr_q  <= s1_ptr_q;
      s2_full_q <= s1_full_q;
      s3_ch_q   <= s2_ch_q;
      s3_sum_q  <= sum_new;
    end
  end

  avg_sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (AW),
    .DEPTH  (NUM_CH << MAX_LOG)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (en & s2_v_q & ~win_chg),
    .waddr_i ({s2_ch_q, s2_ptr_q}),
    .wdata_i (s2_din_q),
    .re_i    (en),
    .raddr_i ({s1_ch_q, s1_ptr_q}),
    .rdata_o (ram_q)
  );

  // Divide the sum by the window size.
`ifdef AVERAGER_ROUND_EN
  logic [SUM_W:0] rnd_sum, rnd_shf;
  always_comb begin
    rnd_sum = {1'b0, s3_sum_q} + ((SUM_W+1)'(1) << (win_q - WL_W'(1)));
    rnd_shf = rnd_sum >> win_q;
    scaled  = (|rnd_shf[SUM_W:DATA_W]) ? '1 : rnd_shf[DATA_W-1:0];
  end
`else
  always_comb begin
    scaled = DATA_W'(s3_sum_q >> win_q);
  end
`endif

  // Output register; holds through disable and window changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_valid_q <= 1'b0;
      dout_ch_q    <= '0;
      dout_q       <= '0;
    end else if (en) begin
      dout_valid_q <= s3_v_q & ~win_chg;
      if (s3_v_q && !win_chg) begin
        dout_q    <= scaled;
        dout_ch_q <= s3_ch_q;
      end
    end
  end

  assign dout_valid = dout_valid_q & en;
  assign dout_ch    = dout_ch_q;
  assign dout       = dout_q;

endmodule

// File: tb/tb_multich_averager.sv
// Directed, self-checking bench for multich_averager (3 channels, MAX_LOG=8).
module tb_multich_averager;

  localparam int DATA_W  = 16;
  localparam int MAX_LOG = 8;
  localparam int NUM_CH  = 3;

  logic        clk = 1'b0;
  logic        reset, en, din_valid;
  logic [3:0]  win_log;
  logic [1:0]  din_ch, dout_ch;
  logic [15:0] din, dout;
  logic        dout_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] d;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        vld;
    logic [1:0]  ch;
    logic [15:0] d;
    logic        ev;
    logic [1:0]  ech;
    int          esum;
  } vec_t;
  vec_t tbl[10];

  multich_averager #(
    .DATA_W  (DATA_W),
    .MAX_LOG (MAX_LOG),
    .NUM_CH  (NUM_CH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .win_log    (win_log),
    .din_valid  (din_valid),
    .din_ch     (din_ch),
    .din        (din),
    .dout_valid (dout_valid),
    .dout_ch    (dout_ch),
    .dout       (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic int exp_div(input int sum, input int lg);
`ifdef AVERAGER_ROUND_EN
    int r;
    r = (sum + (1 << (lg - 1))) >> lg;
    return (r > 65535) ? 65535 : r;
`else
    return sum >> lg;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] ch, input int d);
    exp_q.push_back('{ch, 16'(d)});
  endtask

  // Advance one clock; optionally match any output pulse against the expected queue.
  task automatic tick(input bit sb);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb && dout_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got ch=%0d dout=%0h expected no pulse", dout_ch, dout);
      end else begin
        e = exp_q.pop_front();
        chk("sb_dout_ch", dout_ch, e.ch);
        chk("sb_dout", dout, e.d);
      end
    end
  endtask

  task automatic send(input logic [1:0] ch, input logic [15:0] d);
    din_valid = 1'b1;
    din_ch    = ch;
    din       = d;
    tick(1);
    din_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      tick(1);
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick(1);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; din_valid = 1'b0; din_ch = '0; din = '0; win_log = 4'd8;

    // Power-on reset.
    tick(0);
    tick(0);
    chk("por_dout", dout, 0);
    chk("por_valid", dout_valid, 0);
    reset = 1'b0;
    en = 1'b1;
    tick(1);  // first enabled cycle latches the window

    // Partial window and exact latency.
    push(0, exp_div(16'hFFFF, 8));
    send(0, 16'hFFFF);
    tick(1); chk("lat_n1_valid", dout_valid, 0);
    tick(1); chk("lat_n2_valid", dout_valid, 0);
    tick(1); chk("lat_n3_valid", dout_valid, 1);
    tick(1); chk("lat_n4_valid", dout_valid, 0);
    chk("partial_dout", dout, exp_div(16'hFFFF, 8));

    // Asynchronous reset mid-stream.
    din_valid = 1'b1; din_ch = 2'd0; din = 16'h1234;
    tick(0);
    tick(0);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_dout", dout, 0);
    chk("async_rst_valid", dout_valid, 0);
    tick(0);
    tick(0);
    chk("rst_hold_dout", dout, 0);
    reset = 1'b0;
    din_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("post_rst_valid", dout_valid, 0);
      chk("post_rst_dout", dout, 0);
    end

    // Full window: 256 ones, one zero, then 256 eights.
    din_valid = 1'b1; din_ch = 2'd0;
    for (int k = 1; k <= 256; k++) begin
      din = 16'd1;
      push(0, exp_div(k, 8));
      tick(1);
    end
    din = 16'd0;
    push(0, exp_div(255, 8));
    tick(1);
    for (int j = 1; j <= 256; j++) begin
      din = 16'd8;
      push(0, exp_div((j < 256) ? 255 + 7 * j : 2048, 8));
      tick(1);
    end
    din_valid = 1'b0;
    drain();
    chk("full_window_8", dout, exp_div(2048, 8));

    // Enable low freezes everything and masks dout_valid.
    en = 1'b0; din_valid = 1'b1; din_ch = 2'd0; din = 16'd0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("en0_dout", dout, exp_div(2048, 8));
      chk("en0_valid", dout_valid, 0);
    end
    en = 1'b1;
    push(0, exp_div(2040, 8));
    send(0, 16'd0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("stall_valid", dout_valid, 0);
    end
    en = 1'b1;
    drain();
    chk("en_resume_dout", dout, exp_div(2040, 8));

    // Window change drops the same-cycle sample and flushes in-flight ones.
    send(1, 16'd100);
    win_log = 4'd2;
    send(0, 16'd4);
    for (int i = 0; i < 6; i++) begin
      tick(1);
    end
    chk("winchg_dout_hold", dout, exp_div(2040, 8));
    for (int k = 1; k <= 4; k++) begin
      push(0, exp_div(4 * k, 2));
      send(0, 16'd4);
    end
    drain();

    // Window clamping: 0 -> 1, 15 -> MAX_LOG, and clamped-equal is no change.
    win_log = 4'd0;
    tick(1);
    push(0, exp_div(10, 1));
    send(0, 16'd10);
    drain();
    win_log = 4'd15;
    tick(1);
    push(0, exp_div(256, 8));
    send(0, 16'h0100);
    win_log = 4'd8;
    push(0, exp_div(512, 8));
    send(0, 16'h0100);
    drain();

    // Back-to-back interleaved channels at win_log=2, plus an out-of-range channel.
    win_log = 4'd2;
    tick(1);
    tbl[0] = '{1'b1, 2'd0, 16'd30,  1'b0, 2'd0, 0};
    tbl[1] = '{1'b1, 2'd1, 16'd40,  1'b0, 2'd0, 0};
    tbl[2] = '{1'b1, 2'd0, 16'd40,  1'b0, 2'd0, 0};
    tbl[3] = '{1'b1, 2'd1, 16'd0,   1'b1, 2'd0, 30};
    tbl[4] = '{1'b1, 2'd3, 16'd500, 1'b1, 2'd1, 40};
    tbl[5] = '{1'b1, 2'd2, 16'd9,   1'b1, 2'd0, 70};
    tbl[6] = '{1'b0, 2'd0, 16'd0,   1'b1, 2'd1, 40};
    tbl[7] = '{1'b0, 2'd0, 16'd0,   1'b0, 2'd0, 0};
    tbl[8] = '{1'b0, 2'd0, 16'd0,   1'b1, 2'd2, 9};
    tbl[9] = '{1'b0, 2'd0, 16'd0,   1'b0, 2'd0, 0};
    for (int i = 0; i < 10; i++) begin
      din_valid = tbl[i].vld;
      din_ch    = tbl[i].ch;
      din       = tbl[i].d;
      tick(0);
      chk($sformatf("tbl%0d_valid", i), dout_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_ch", i), dout_ch, tbl[i].ech);
        chk($sformatf("tbl%0d_dout", i), dout, exp_div(tbl[i].esum, 2));
      end
    end
    din_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
